temp_scan_ctrl: RTL
===================

TEMP_SCAN_CTRL -- requirements
Module: temp_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 3, SHALL set the mux settle cycles after temp_sel_o changes (legal 1..15).
REQ-002 Parameter TIMEOUT_CYC, default 4095, SHALL set the maximum WAIT cycles before a conversion is declared failed (legal 1..4095).
REQ-003 clk_i  in  1  SHALL be the system clock; all flops SHALL be rising-edge.
REQ-004 rst_n_i  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 en_i  in  1  SHALL enable continuous round-robin scanning.
REQ-006 chan_mask_i  in  4  SHALL mark sensor channels 0..3 as included in the scan (bit n = channel n).
REQ-007 temp_sel_o  out  2  SHALL drive the sensor-select input of the config register/mux block.
REQ-008 start_o  out  1  SHALL be the conversion-start pulse to the selected sensor.
REQ-009 done_i  in  1  SHALL be the muxed conversion-done from the selected sensor; it is level-sensitive and synchronous to clk_i.
REQ-010 ticks_i  in  12  SHALL be the muxed temp_ticks result.
REQ-011 dac_i  in  6  SHALL be the muxed temp_dac result.
REQ-012 res_valid_o  out  1  SHALL be a one-cycle result strobe.
REQ-013 res_chan_o  out  2, res_ticks_o  out  12, res_dac_o  out  6  SHALL be the result channel and data, valid while res_valid_o=1 and held until the next strobe.
REQ-014 timeout_o  out  1  SHALL flag the current result as a timeout and is valid with res_valid_o.
REQ-015 busy_o  out  1  SHALL be 1 in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, START, WAIT and STORE.
REQ-017 IDLE -> SETTLE SHALL occur when en_i=1 and chan_mask_i!=0; temp_sel_o SHALL load the lowest set mask bit on that edge.
REQ-018 SETTLE SHALL last exactly SETTLE_CYC cycles, then go to START.
REQ-019 START SHALL last 1 cycle with start_o=1, then go to WAIT; start_o SHALL be 0 in all other states.
REQ-020 done_i SHALL be sampled only in WAIT; done_i=1 during SETTLE or START SHALL be ignored.
REQ-021 In WAIT, done_i=1 SHALL capture ticks_i and dac_i on that edge and go to STORE, with timeout_o=0.
REQ-022 In WAIT, after TIMEOUT_CYC cycles without done_i, the block SHALL go to STORE with timeout_o=1, res_ticks_o=12'hFFF and res_dac_o=6'h00.
REQ-023 If done_i and the timeout coincide in the same cycle, done_i SHALL win (timeout_o=0).
REQ-024 In STORE (1 cycle), res_valid_o SHALL be 1 and res_chan_o SHALL equal temp_sel_o.
REQ-025 From STORE the block SHALL go to SETTLE and select the next set mask bit above the current channel, wrapping 3 -> 0.
REQ-026 If only the current channel is set, the block SHALL reselect the same channel and still run the full SETTLE period.
REQ-027 From STORE the block SHALL go to IDLE if en_i=0 or chan_mask_i=0; temp_sel_o SHALL hold its value.
REQ-028 chan_mask_i SHALL be sampled only at channel selection (IDLE->SETTLE, STORE->SETTLE); a mask change mid-conversion SHALL NOT abort it.
REQ-029 en_i=0 in SETTLE, START or WAIT SHALL force IDLE on the next edge with no result strobe; start_o SHALL deassert on that same edge.
REQ-030 Latency from the start_o cycle to res_valid_o SHALL be N+1 cycles, where done_i is first high in the Nth WAIT cycle.
REQ-031 Settle and timeout counters SHALL be 12 bit, saturating, and SHALL clear on every state entry.

Reset
REQ-032 With rst_n_i=0, the block SHALL asynchronously enter IDLE with every output 0: temp_sel_o=0, start_o=0, res_valid_o=0, res_chan_o=0, res_ticks_o=0, res_dac_o=0, timeout_o=0, busy_o=0; all counters SHALL also clear.
REQ-033 After rst_n_i deasserts, the first transition SHALL occur no earlier than the first rising edge with rst_n_i=1.
REQ-034 Reset asserted mid-conversion SHALL abort immediately with no result strobe.

Verification
REQ-035 Mask 4'b1111, en_i=1, done_i returned 5 cycles after start_o with ticks 0x123 -> results on channels 0,1,2,3,0 in order, each with res_ticks_o=0x123 and timeout_o=0.
REQ-036 Mask 4'b1010 -> temp_sel_o sequence 1,3,1,3; exactly SETTLE_CYC=3 cycles between each temp_sel_o change and start_o.
REQ-037 TIMEOUT_CYC=8, done_i never asserted -> res_valid_o 9 cycles after start_o with timeout_o=1, res_ticks_o=0xFFF, res_dac_o=0.
REQ-038 done_i high during START, then low in WAIT -> no capture; a timeout result is produced.
REQ-039 en_i dropped in WAIT -> IDLE next cycle, busy_o=0, no res_valid_o pulse; re-enable restarts at the lowest set mask bit.
REQ-040 rst_n_i pulsed low mid-WAIT, asynchronously between clock edges -> all outputs 0 immediately; scanning resumes from channel 0 after release.

Source files
------------

// File: rtl/temp_scan_ctrl.sv
// Round-robin temperature sensor scan controller.
// Walks the enabled sensor channels, lets the select mux settle, pulses a
// conversion start, waits for done (or times out) and presents one result
// per conversion with a single-cycle strobe.
module temp_scan_ctrl #(
  parameter int SETTLE_CYC  = 3,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic [3:0]  chan_mask_i,
  output logic [1:0]  temp_sel_o,
  output logic        start_o,
  input  logic        done_i,
  input  logic [11:0] ticks_i,
  input  logic [5:0]  dac_i,
  output logic        res_valid_o,
  output logic [1:0]  res_chan_o,
  output logic [11:0] res_ticks_o,
  output logic [5:0]  res_dac_o,
  output logic        timeout_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_STORE
  } state_t;

  // Counter value seen in the last cycle of SETTLE / WAIT (counter is 0 on entry).
  localparam logic [11:0] SETTLE_LAST  = 12'(SETTLE_CYC - 1);
  localparam logic [11:0] TIMEOUT_LAST = 12'(TIMEOUT_CYC - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [11:0] r_cnt;
  logic [1:0]  r_sel;
  logic [1:0]  w_sel_next;
  logic        w_capture;
  logic        w_capture_to;

  logic [1:0]  r_res_chan;
  logic [11:0] r_res_ticks;
  logic [5:0]  r_res_dac;
  logic        r_timeout;

  // Mask rotated so bit gi is the channel gi+1 steps above the current one;
  // bit 3 lands back on the current channel itself.
  logic [3:0]  w_rot_mask;
  logic [1:0]  w_low_chan;
  logic [1:0]  w_next_chan;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rot
      assign w_rot_mask[gi] = chan_mask_i[r_sel + 2'(gi + 1)];
    end
  endgenerate

  // Pick the lowest set channel (fresh start) and the next set channel above the current one.
  always_comb begin
    w_low_chan  = 2'd0;
    w_next_chan = r_sel;
    for (int i = 3; i >= 0; i--) begin
      if (chan_mask_i[i]) begin
        w_low_chan = 2'(i);
      end
      if (w_rot_mask[i]) begin
        w_next_chan = r_sel + 2'(i + 1);
      end
    end
  end

  // Next-state logic; dropping en_i abandons any conversion in flight without a result.
  always_comb begin
    w_state_next = r_state;
    w_sel_next   = r_sel;
    w_capture    = 1'b0;
    w_capture_to = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (en_i && (chan_mask_i != 4'd0)) begin
          w_state_next = S_SETTLE;
          w_sel_next   = w_low_chan;
        end
      end
      S_SETTLE: begin
        if (!en_i) begin
          w_state_next = S_IDLE;
        end else if (r_cnt >= SETTLE_LAST) begin
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (!en_i) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!en_i) begin
          w_state_next = S_IDLE;
        end else if (done_i) begin
          // done takes priority over a timeout expiring in the same cycle
          w_state_next = S_STORE;
          w_capture    = 1'b1;
        end else if (r_cnt >= TIMEOUT_LAST) begin
          w_state_next = S_STORE;
          w_capture_to = 1'b1;
        end
      end
      S_STORE: begin
        if (en_i && (chan_mask_i != 4'd0)) begin
          w_state_next = S_SETTLE;
          w_sel_next   = w_next_chan;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // State, channel select and the shared settle/timeout counter (cleared on every state entry).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_sel   <= 2'd0;
      r_cnt   <= 12'd0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      if (w_state_next != r_state) begin
        r_cnt <= 12'd0;
      end else if (r_cnt != 12'hFFF) begin
        r_cnt <= r_cnt + 12'd1;
      end
    end
  end

  // Result registers: loaded on the way into STORE and held until the next result.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_res_chan  <= 2'd0;
      r_res_ticks <= 12'd0;
      r_res_dac   <= 6'd0;
      r_timeout   <= 1'b0;
    end else if (w_capture) begin
      r_res_chan  <= r_sel;
      r_res_ticks <= ticks_i;
      r_res_dac   <= dac_i;
      r_timeout   <= 1'b0;
    end else if (w_capture_to) begin
      r_res_chan  <= r_sel;
      r_res_ticks <= 12'hFFF;
      r_res_dac   <= 6'h00;
      r_timeout   <= 1'b1;
    end
  end

  assign temp_sel_o  = r_sel;
  assign start_o     = (r_state == S_START);
  assign res_valid_o = (r_state == S_STORE);
  assign busy_o      = (r_state != S_IDLE);
  assign res_chan_o  = r_res_chan;
  assign res_ticks_o = r_res_ticks;
  assign res_dac_o   = r_res_dac;
  assign timeout_o   = r_timeout;

endmodule
